// File: rtl/mc_pkg.sv
// Shared types and constants for the missionary-cannibal solver sequencer.
// Provides the puzzle state struct, start/goal constants, error codes and the
// sequencer FSM state enum.
package mc_pkg;

    // Left-bank counts plus boat side (0 = left bank, 1 = right bank)
    typedef struct packed {
        logic [1:0] m;
        logic [1:0] c;
        logic       dir;
    } mc_state_t;

    localparam mc_state_t MC_RESET = '{m: 2'd0, c: 2'd0, dir: 1'b0};
    localparam mc_state_t MC_START = '{m: 2'd3, c: 2'd3, dir: 1'b0};
    localparam mc_state_t MC_GOAL  = '{m: 2'd0, c: 2'd0, dir: 1'b1};

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MOVE    = 2'b01;
    localparam logic [1:0] ERR_UNSAFE  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } fsm_t;

endpackage

// File: rtl/mc_solver_sequencer_if.sv
// Bundles the sequencer's control, solver and trace signals.
// master: run controller / solver / trace consumer side (drives start, abort,
//         solver_*_next, out_ready).
// slave:  sequencer side (drives solver_*_curr, trace record and status).
interface mc_solver_sequencer_if #(
    parameter int unsigned STEP_W = 4
);
    logic              start;
    logic              abort;
    logic [1:0]        solver_m_curr;
    logic [1:0]        solver_c_curr;
    logic              solver_dir;
    logic [1:0]        solver_m_next;
    logic [1:0]        solver_c_next;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_m;
    logic [1:0]        out_c;
    logic              out_dir;
    logic [STEP_W-1:0] out_step;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output start, abort, solver_m_next, solver_c_next, out_ready,
        input  solver_m_curr, solver_c_curr, solver_dir, out_valid,
               out_m, out_c, out_dir, out_step, busy, done, err, err_code
    );

    modport slave (
        input  start, abort, solver_m_next, solver_c_next, out_ready,
        output solver_m_curr, solver_c_curr, solver_dir, out_valid,
               out_m, out_c, out_dir, out_step, busy, done, err, err_code
    );
endinterface

// File: rtl/mc_move_checker.sv
// Combinational legality and safety check of a proposed crossing.
// Ports: curr_i (current state), m_next_i/c_next_i (proposed left-bank
// counts), move_ok_o (boat load 1..2 in the right direction),
// safe_ok_o (neither bank has missionaries outnumbered).
module mc_move_checker
    import mc_pkg::*;
(
    input  mc_state_t  curr_i,
    input  logic [1:0] m_next_i,
    input  logic [1:0] c_next_i,
    output logic       move_ok_o,
    output logic       safe_ok_o
);
    logic [2:0] dm;
    logic [2:0] dc;
    logic [2:0] load;
    logic       dir_ok;
    logic [1:0] right_m;
    logic [1:0] right_c;

    always_comb begin
        dir_ok = 1'b1;
        dm     = 3'd0;
        dc     = 3'd0;
        // Boat on the left carries people away from it; on the right it brings them back.
        // Differences only matter when dir_ok holds, so wrap on a bad direction is harmless.
        if (!curr_i.dir) begin
            dir_ok = (m_next_i <= curr_i.m) && (c_next_i <= curr_i.c);
            dm     = 3'(curr_i.m) - 3'(m_next_i);
            dc     = 3'(curr_i.c) - 3'(c_next_i);
        end else begin
            dir_ok = (m_next_i >= curr_i.m) && (c_next_i >= curr_i.c);
            dm     = 3'(m_next_i) - 3'(curr_i.m);
            dc     = 3'(c_next_i) - 3'(curr_i.c);
        end
        load      = dm + dc;
        move_ok_o = dir_ok && ((load == 3'd1) || (load == 3'd2));

        right_m   = 2'd3 - m_next_i;
        right_c   = 2'd3 - c_next_i;
        safe_ok_o = !(((m_next_i != 2'd0) && (m_next_i < c_next_i)) ||
                      ((right_m  != 2'd0) && (right_m  < right_c)));
    end
endmodule

// File: rtl/mc_solver_sequencer.sv
// Sequences a river-crossing run: holds the puzzle state, feeds it to the
// external next-state block, validates each returned move and streams every
// visited state as a trace record.
// Ports: clk, reset (async active-high), bus (slave modport: start/abort,
// solver current/next state, out_* trace record with valid/ready, busy,
// done, err, err_code).
module mc_solver_sequencer
    import mc_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 15,
    parameter int unsigned STEP_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mc_solver_sequencer_if.slave  bus
);
    fsm_t              state_q, state_d;
    mc_state_t         pos_q, pos_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic move_ok;
    logic safe_ok;

    mc_move_checker u_checker (
        .curr_i    (pos_q),
        .m_next_i  (bus.solver_m_next),
        .c_next_i  (bus.solver_c_next),
        .move_ok_o (move_ok),
        .safe_ok_o (safe_ok)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pos_q   <= MC_RESET;
            step_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic; abort outranks start and any handshake
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        step_d  = step_q;
        valid_d = valid_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;

        if (bus.abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start) begin
                        state_d = ST_EMIT;
                        pos_d   = MC_START;
                        step_d  = '0;
                        valid_d = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        code_d  = ERR_NONE;
                    end
                end
                ST_EMIT: begin
                    if (valid_q && bus.out_ready) begin
                        // The current record has just been accepted; decide what follows it.
                        if (pos_q == MC_GOAL) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else if (step_q == STEP_W'(MAX_STEPS)) begin
                            state_d = ST_ERROR;
                            valid_d = 1'b0;
                            err_d   = 1'b1;
                            code_d  = ERR_TIMEOUT;
                        end else if (!move_ok) begin
                            state_d = ST_ERROR;
                            valid_d = 1'b0;
                            err_d   = 1'b1;
                            code_d  = ERR_MOVE;
                        end else if (!safe_ok) begin
                            state_d = ST_ERROR;
                            valid_d = 1'b0;
                            err_d   = 1'b1;
                            code_d  = ERR_UNSAFE;
                        end else begin
                            pos_d.m   = bus.solver_m_next;
                            pos_d.c   = bus.solver_c_next;
                            pos_d.dir = ~pos_q.dir;
                            step_d    = step_q + STEP_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.solver_m_curr = pos_q.m;
    assign bus.solver_c_curr = pos_q.c;
    assign bus.solver_dir    = pos_q.dir;
    assign bus.out_m         = pos_q.m;
    assign bus.out_c         = pos_q.c;
    assign bus.out_dir       = pos_q.dir;
    assign bus.out_step      = step_q;
    assign bus.out_valid     = valid_q;
    assign bus.busy          = valid_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.err_code      = code_q;

endmodule

// File: tb/tb_mc_solver_sequencer.sv
// Bench for mc_solver_sequencer: directed vector table, hand-written corner
// sequences and randomized runs checked against a rule-level model.
module tb_mc_solver_sequencer;
    import mc_pkg::*;

    localparam int unsigned MAXS  = 15;
    localparam int unsigned SW    = 4;
    localparam int unsigned MAXS2 = 3;
    localparam int unsigned SW2   = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_solver_sequencer_if #(.STEP_W(SW))  sif ();
    mc_solver_sequencer_if #(.STEP_W(SW2)) tif ();

    mc_solver_sequencer #(.MAX_STEPS(MAXS), .STEP_W(SW)) dut (
        .clk(clk), .reset(reset), .bus(sif.slave)
    );
    mc_solver_sequencer #(.MAX_STEPS(MAXS2), .STEP_W(SW2)) dut_to (
        .clk(clk), .reset(reset), .bus(tif.slave)
    );

    int total = 0;
    int bad   = 0;

    // Canonical 11-crossing path
    int path_m [12] = '{3, 3, 3, 3, 3, 1, 2, 0, 0, 0, 0, 0};
    int path_c [12] = '{3, 1, 2, 0, 1, 1, 2, 2, 3, 1, 2, 0};
    int path_d [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    // Stub modes: 0 golden, 1 unsafe from 33L, 2 empty boat from 33L, 3 decrease at 31R, 4 random
    int         mode  = 0;
    logic [1:0] rnd_m = 2'd0;
    logic [1:0] rnd_c = 2'd0;

    function automatic logic [3:0] propose(int md, logic [1:0] m, logic [1:0] c, logic d,
                                           logic [1:0] rm, logic [1:0] rc);
        logic [3:0] r;
        r = {m, c};
        if (md == 4) return {rm, rc};
        if (md == 1 && m == 2'd3 && c == 2'd3 && !d) return {2'd1, 2'd3};
        if (md == 2 && m == 2'd3 && c == 2'd3 && !d) return {2'd3, 2'd3};
        if (md == 3 && m == 2'd3 && c == 2'd1 && d)  return {2'd3, 2'd0};
        for (int i = 0; i < 11; i++)
            if (int'(m) == path_m[i] && int'(c) == path_c[i] && int'(d) == path_d[i])
                r = {2'(path_m[i+1]), 2'(path_c[i+1])};
        return r;
    endfunction

    always_comb begin
        {sif.solver_m_next, sif.solver_c_next} =
            propose(mode, sif.solver_m_curr, sif.solver_c_curr, sif.solver_dir, rnd_m, rnd_c);
    end

    // Oscillating stub for the timeout instance: 33L -> 31R -> 33L ...
    always_comb begin
        if (tif.solver_m_curr == 2'd3 && tif.solver_c_curr == 2'd3)
            {tif.solver_m_next, tif.solver_c_next} = {2'd3, 2'd1};
        else
            {tif.solver_m_next, tif.solver_c_next} = {2'd3, 2'd3};
    end

    // Reference model: phase 0 idle, 1 emitting, 2 done, 3 error
    int e_m = 0, e_c = 0, e_dir = 0, e_step = 0, e_ph = 0, e_code = 0;

    typedef struct { int m; int c; int d; int s; } rec_t;
    rec_t recs[$];

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("out_valid", int'(sif.out_valid), int'(e_ph == 1));
        chk("busy",      int'(sif.busy),      int'(e_ph == 1));
        chk("done",      int'(sif.done),      int'(e_ph == 2));
        chk("err",       int'(sif.err),       int'(e_ph == 3));
        chk("err_code",  int'(sif.err_code),  e_code);
        chk("solver_m",  int'(sif.solver_m_curr), e_m);
        chk("solver_c",  int'(sif.solver_c_curr), e_c);
        chk("solver_dir", int'(sif.solver_dir),   e_dir);
        chk("out_m",     int'(sif.out_m),     e_m);
        chk("out_c",     int'(sif.out_c),     e_c);
        chk("out_dir",   int'(sif.out_dir),   e_dir);
        chk("out_step",  int'(sif.out_step),  e_step);
    endtask

    task automatic model_step(logic st, logic ab, logic rdy, int pn_m, int pn_c);
        int  ld;
        bit  badmv, unsafe;
        if (ab) begin
            e_ph = 0; e_code = 0;
        end else if (e_ph != 1) begin
            if (st) begin
                e_m = 3; e_c = 3; e_dir = 0; e_step = 0; e_ph = 1; e_code = 0;
            end
        end else if (rdy) begin
            ld     = iabs(e_m - pn_m) + iabs(e_c - pn_c);
            badmv  = (ld < 1) || (ld > 2) ||
                     (e_dir == 0 && (pn_m > e_m || pn_c > e_c)) ||
                     (e_dir == 1 && (pn_m < e_m || pn_c < e_c));
            unsafe = (pn_m > 0 && pn_m < pn_c) || ((3 - pn_m) > 0 && (3 - pn_m) < (3 - pn_c));
            if (e_m == 0 && e_c == 0 && e_dir == 1) e_ph = 2;
            else if (e_step == int'(MAXS)) begin e_ph = 3; e_code = 3; end
            else if (badmv)  begin e_ph = 3; e_code = 1; end
            else if (unsafe) begin e_ph = 3; e_code = 2; end
            else begin
                e_m = pn_m; e_c = pn_c; e_dir = 1 - e_dir; e_step++;
            end
        end
    endtask

    // One clock: drive inputs, step the model across the edge, check after it
    task automatic cycle(logic st, logic ab, logic rdy);
        int k, dm, dc, nm, nc;
        logic [3:0] p;
        if (mode == 4) begin
            k  = int'($urandom_range(4));
            dm = (k == 0 || k == 4) ? 1 : (k == 1) ? 2 : 0;
            dc = (k == 2 || k == 4) ? 1 : (k == 3) ? 2 : 0;
            nm = (e_dir != 0) ? e_m + dm : e_m - dm;
            nc = (e_dir != 0) ? e_c + dc : e_c - dc;
            if ($urandom_range(3) == 0 || nm < 0 || nm > 3 || nc < 0 || nc > 3) begin
                nm = int'($urandom_range(3));
                nc = int'($urandom_range(3));
            end
            rnd_m = 2'(nm);
            rnd_c = 2'(nc);
        end
        sif.start     = st;
        sif.abort     = ab;
        sif.out_ready = rdy;
        p = propose(mode, 2'(e_m), 2'(e_c), 1'(e_dir), rnd_m, rnd_c);
        #1;
        if (sif.out_valid && rdy && !ab)
            recs.push_back('{int'(sif.out_m), int'(sif.out_c), int'(sif.out_dir), int'(sif.out_step)});
        @(posedge clk);
        model_step(st, ab, rdy, int'(p[3:2]), int'(p[1:0]));
        #1;
        chk_all();
    endtask

    typedef struct {
        int mode; int rdy_pat; int exp_ph; int exp_code; int exp_nrec; int fm; int fc; int fd;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   n;
        logic rdy, ab;
        int   tsteps[$];
        int   tms[$];

        vecs[0] = '{0, 0, 2, 0, 12, 0, 0, 1};
        vecs[1] = '{0, 1, 2, 0, 12, 0, 0, 1};
        vecs[2] = '{1, 0, 3, 2,  1, 3, 3, 0};
        vecs[3] = '{2, 0, 3, 1,  1, 3, 3, 0};
        vecs[4] = '{3, 0, 3, 1,  2, 3, 1, 1};

        sif.start = 1'b0; sif.abort = 1'b0; sif.out_ready = 1'b0;
        tif.start = 1'b0; tif.abort = 1'b0; tif.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_all();
        chk("to_reset_valid", int'(tif.out_valid), 0);
        chk("to_reset_err",   int'(tif.err), 0);
        reset = 1'b0;
        #1;
        chk_all();

        // Directed vector table
        foreach (vecs[v]) begin
            mode = vecs[v].mode;
            recs.delete();
            cycle(1'b1, 1'b0, 1'b0);
            n = 0;
            while (e_ph == 1 && n < 200) begin
                rdy = (vecs[v].rdy_pat == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
                cycle(1'b0, 1'b0, rdy);
                n++;
            end
            chk("vec_bound", int'(n < 200), 1);
            chk("vec_done",  int'(sif.done), int'(vecs[v].exp_ph == 2));
            chk("vec_err",   int'(sif.err),  int'(vecs[v].exp_ph == 3));
            chk("vec_code",  int'(sif.err_code), vecs[v].exp_code);
            chk("vec_nrec",  recs.size(), vecs[v].exp_nrec);
            chk("vec_fm",    int'(sif.solver_m_curr), vecs[v].fm);
            chk("vec_fc",    int'(sif.solver_c_curr), vecs[v].fc);
            chk("vec_fd",    int'(sif.solver_dir),    vecs[v].fd);
            foreach (recs[i]) begin
                if (i < 12) begin
                    chk("rec_m",    recs[i].m, path_m[i]);
                    chk("rec_c",    recs[i].c, path_c[i]);
                    chk("rec_d",    recs[i].d, path_d[i]);
                    chk("rec_step", recs[i].s, i);
                end
            end
            cycle(1'b0, 1'b0, 1'b1);
        end

        // Abort while stalled at step 5, then restart
        mode = 0;
        cycle(1'b1, 1'b0, 1'b1);
        n = 0;
        while (e_step < 5 && n < 50) begin cycle(1'b0, 1'b0, 1'b1); n++; end
        chk("abort_reach_step5", int'(sif.out_step), 5);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("abort_valid", int'(sif.out_valid), 0);
        chk("abort_done",  int'(sif.done), 0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("restart_step",  int'(sif.out_step), 0);
        chk("restart_m",     int'(sif.out_m), 3);
        chk("restart_c",     int'(sif.out_c), 3);
        chk("restart_valid", int'(sif.out_valid), 1);
        n = 0;
        while (e_ph == 1 && n < 100) begin cycle(1'b0, 1'b0, 1'b1); n++; end
        chk("restart_done", int'(sif.done), 1);

        // Asynchronous reset mid-run
        cycle(1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_valid", int'(sif.out_valid), 0);
        chk("arst_busy",  int'(sif.busy), 0);
        chk("arst_m",     int'(sif.out_m), 0);
        chk("arst_c",     int'(sif.out_c), 0);
        chk("arst_step",  int'(sif.out_step), 0);
        e_m = 0; e_c = 0; e_dir = 0; e_step = 0; e_ph = 0; e_code = 0;
        #1;
        reset = 1'b0;
        chk_all();

        // Randomized runs against the model
        mode = 4;
        for (int r = 0; r < 12; r++) begin
            cycle(1'b1, 1'b0, 1'($urandom_range(1)));
            n = 0;
            while (e_ph == 1 && n < 200) begin
                rdy = ($urandom_range(3) != 0);
                ab  = ($urandom_range(59) == 0);
                cycle(1'b0, ab, rdy);
                n++;
            end
            chk("rand_bound", int'(n < 200), 1);
        end

        // Timeout with MAX_STEPS=3 on the second instance
        tif.start = 1'b1;
        tif.out_ready = 1'b1;
        @(posedge clk); #1;
        tif.start = 1'b0;
        n = 0;
        while (!tif.err && n < 20) begin
            if (tif.out_valid) begin
                tsteps.push_back(int'(tif.out_step));
                tms.push_back(int'(tif.out_c));
            end
            @(posedge clk); #1;
            n++;
        end
        chk("to_bound", int'(n < 20), 1);
        chk("to_nrec",  tsteps.size(), 4);
        foreach (tsteps[i]) begin
            chk("to_step", tsteps[i], i);
            chk("to_c",    tms[i], (i % 2 == 0) ? 3 : 1);
        end
        chk("to_err",   int'(tif.err), 1);
        chk("to_code",  int'(tif.err_code), 3);
        chk("to_hold_step", int'(tif.out_step), 3);
        repeat (2) @(posedge clk);
        #1;
        chk("to_no_step4", int'(tif.out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
